// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational WIDTH x WIDTH multiplier between
// two requesters, with registered operands, captured result and an overflow counter.
module mult_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_error,
  output logic [WIDTH-1:0] mult_first,
  output logic [WIDTH-1:0] mult_second,
  input  logic [WIDTH-1:0] mult_out,
  input  logic             mult_error,
  output logic             busy,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   prio;
  logic   grant0, grant1;
  logic   acc0, acc1;
  logic   resp_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant0      = 1'b0;
    grant1      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp_hs     = 1'b0;
    busy        = (state != IDLE);

    // A lone requester always wins; a tie goes to prio.
    grant0 = req0_valid && (!req1_valid || !prio);
    grant1 = req1_valid && (!req0_valid ||  prio);

    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_nxt = CALC;
      end
      CALC: state_nxt = HOLD;
      HOLD: begin
        resp0_valid = !owner;
        resp1_valid =  owner;
        resp_hs     = owner ? resp1_ready : resp0_ready;
        if (resp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_first  <= '0;
      mult_second <= '0;
      resp_result <= '0;
      resp_error  <= 1'b0;
      ovf_count   <= '0;
      owner       <= 1'b0;
      prio        <= 1'b0;
    end else begin
      if (acc0) begin
        mult_first  <= req0_a;
        mult_second <= req0_b;
        owner       <= 1'b0;
        prio        <= 1'b1;
      end else if (acc1) begin
        mult_first  <= req1_a;
        mult_second <= req1_b;
        owner       <= 1'b1;
        prio        <= 1'b0;
      end
      if (state == CALC) begin
        resp_result <= mult_out;
        resp_error  <= mult_error;
        if (mult_error && (ovf_count != '1)) ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

endmodule
